// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, and a
// pixel-rate output stage with sync and colour registered together.
module vga_timing_gen #(
    parameter int CW   = 3,
    parameter int DIV  = 2,
    parameter int HD   = 640,
    parameter int HF   = 16,
    parameter int HR   = 96,
    parameter int HB   = 48,
    parameter int VD   = 480,
    parameter int VF   = 10,
    parameter int VR   = 2,
    parameter int VB   = 33,
    parameter int HPOL = 0,
    parameter int VPOL = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3*CW-1:0] rgb_in,
    output logic            hsync,
    output logic            vsync,
    output logic [CW-1:0]   red,
    output logic [CW-1:0]   green,
    output logic [CW-1:0]   blue,
    output logic            video_on,
    output logic            p_tick,
    output logic            line_tick,
    output logic            frame_tick,
    output logic [10:0]     pixel_x,
    output logic [10:0]     pixel_y
);

    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;

    localparam logic [3:0]  DIV_LAST = 4'(DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(HT - 1);
    localparam logic [10:0] V_LAST   = 11'(VT - 1);
    localparam logic [10:0] H_VIS    = 11'(HD);
    localparam logic [10:0] V_VIS    = 11'(VD);
    localparam logic [10:0] HS_BEG   = 11'(HD + HF);
    localparam logic [10:0] HS_END   = 11'(HD + HF + HR - 1);
    localparam logic [10:0] VS_BEG   = 11'(VD + VF);
    localparam logic [10:0] VS_END   = 11'(VD + VF + VR - 1);
    localparam logic        H_ACT    = 1'(HPOL);
    localparam logic        V_ACT    = 1'(VPOL);

    logic [3:0]  div_cnt;
    logic [10:0] h;
    logic [10:0] v;
    logic        h_last;
    logic        v_last;
    logic        hsync_act;
    logic        vsync_act;

    // p_tick is a one-cycle strobe: every consumer advances exactly once per
    // cycle in which it is high; there is no back-pressure.
    always_comb begin
        p_tick     = (div_cnt == DIV_LAST) && !reset;
        h_last     = (h == H_LAST);
        v_last     = (v == V_LAST);
        line_tick  = p_tick && h_last;
        frame_tick = p_tick && h_last && v_last;
        video_on   = (h < H_VIS) && (v < V_VIS);
        hsync_act  = (h >= HS_BEG) && (h <= HS_END);
        vsync_act  = (v >= VS_BEG) && (v <= VS_END);
        pixel_x    = h;
        pixel_y    = v;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (p_tick) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? 11'd0 : v + 11'd1;
            end else begin
                h <= h + 11'd1;
            end
        end
    end

    // Sync and colour sample the same counter values so they stay aligned
    // one pixel behind the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync <= ~H_ACT;
            vsync <= ~V_ACT;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (p_tick) begin
            hsync <= hsync_act ? H_ACT : ~H_ACT;
            vsync <= vsync_act ? V_ACT : ~V_ACT;
            red   <= video_on ? rgb_in[CW-1:0]      : '0;
            green <= video_on ? rgb_in[2*CW-1:CW]   : '0;
            blue  <= video_on ? rgb_in[3*CW-1:2*CW] : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster: random colour and reset
// stimulus, per-cycle expected outputs from a tick-count reference model.
module tb_vga_timing_gen;

    localparam int CW   = 4;
    localparam int DIV  = 3;
    localparam int HD   = 4;
    localparam int HF   = 1;
    localparam int HR   = 2;
    localparam int HB   = 1;
    localparam int VD   = 3;
    localparam int VF   = 1;
    localparam int VR   = 1;
    localparam int VB   = 1;
    localparam int HPOL = 1;
    localparam int VPOL = 0;
    localparam int HT   = HD + HF + HR + HB;
    localparam int VT   = VD + VF + VR + VB;
    localparam int W    = 2 + 3 * CW + 4 + 22;
    localparam int N    = 3000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3*CW-1:0] rgb_in = '0;
    logic            hsync;
    logic            vsync;
    logic [CW-1:0]   red;
    logic [CW-1:0]   green;
    logic [CW-1:0]   blue;
    logic            video_on;
    logic            p_tick;
    logic            line_tick;
    logic            frame_tick;
    logic [10:0]     pixel_x;
    logic [10:0]     pixel_y;

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    vga_timing_gen #(
        .CW(CW), .DIV(DIV), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB), .HPOL(HPOL), .VPOL(VPOL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rgb_in(rgb_in),
        .hsync(hsync),
        .vsync(vsync),
        .red(red),
        .green(green),
        .blue(blue),
        .video_on(video_on),
        .p_tick(p_tick),
        .line_tick(line_tick),
        .frame_tick(frame_tick),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y)
    );

    always #5 clk = ~clk;

    // Reference model: position derived from clock cycles since reset.
    int run;
    logic m_hs;
    logic m_vs;
    logic [CW-1:0] m_r;
    logic [CW-1:0] m_g;
    logic [CW-1:0] m_b;

    initial begin
        int rst_left;
        int ticks;
        int pos;
        int h;
        int v;
        logic p;
        logic lt;
        logic ft;
        logic vid;
        run  = 0;
        m_hs = ~1'(HPOL);
        m_vs = ~1'(VPOL);
        m_r  = '0;
        m_g  = '0;
        m_b  = '0;
        rst_left = 2;
        repeat (3) @(posedge clk);
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            #1;
            if (rst_left == 0 && i > 2 * DIV * HT * VT + 20 && $urandom_range(0, 149) == 0)
                rst_left = $urandom_range(1, 2);
            reset = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            rgb_in = ((i % 500) < 150) ? {3*CW{1'b1}} : (3*CW)'($urandom);

            ticks = run / DIV;
            pos   = ticks % (HT * VT);
            h     = pos % HT;
            v     = pos / HT;
            p     = !reset && ((run % DIV) == DIV - 1);
            lt    = p && (h == HT - 1);
            ft    = lt && (v == VT - 1);
            vid   = (h < HD) && (v < VD);
            exp_q.push_back({m_hs, m_vs, m_r, m_g, m_b, vid, p, lt, ft, 11'(h), 11'(v)});

            if (reset) begin
                run  = 0;
                m_hs = ~1'(HPOL);
                m_vs = ~1'(VPOL);
                m_r  = '0;
                m_g  = '0;
                m_b  = '0;
            end else begin
                if (p) begin
                    m_hs = (h >= HD + HF && h < HD + HF + HR) ? 1'(HPOL) : ~1'(HPOL);
                    m_vs = (v >= VD + VF && v < VD + VF + VR) ? 1'(VPOL) : ~1'(VPOL);
                    m_r  = vid ? rgb_in[CW-1:0]      : '0;
                    m_g  = vid ? rgb_in[2*CW-1:CW]   : '0;
                    m_b  = vid ? rgb_in[3*CW-1:2*CW] : '0;
                end
                run++;
            end
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_got;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_got = {hsync, vsync, red, green, blue, video_on, p_tick,
                           line_tick, frame_tick, pixel_x, pixel_y};
                vectors++;
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL outputs vec %0d t=%0t got=%h required=%h",
                             vectors, $time, mon_got, mon_exp);
                end
            end
        end
    end

endmodule
